square_wave_detector: RTL and testbench



---
 rtl/square_wave_detector_pkg.sv | 23 ++
 rtl/square_wave_detector_level_slicer.sv | 60 ++++++
 rtl/square_wave_detector.sv | 137 +++++++++++++
 tb/tb_square_wave_detector.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/square_wave_detector_pkg.sv
// Shared audio-path definitions for the tone detector: FSM states, default
// slicer/lock constants and the 440 Hz reference period.
package square_wave_detector_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

    localparam logic [31:0] DEF_THRESHOLD  = 32'd5_000_000;
    localparam logic [19:0] DEF_TOLERANCE  = 20'd1_000;
    localparam int          DEF_COUNT_W    = 20;
    localparam int          DEF_LOCK_COUNT = 4;

    // Two half periods of the oscillator's 56_818 terminal count (+1 each).
    localparam logic [19:0] PERIOD_440HZ   = 20'd113_638;

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/square_wave_detector_level_slicer.sv
// Hysteresis slicer: turns signed samples into a held binary level and
// flags the 0->1 transitions of that level.
module level_slicer
    import square_wave_detector_pkg::*;
#(
    parameter logic [31:0] THRESHOLD = DEF_THRESHOLD
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] sample_i,
    input  logic        valid_i,
    output logic        level_o,
    output logic        level_known_o,
    output logic        rise_o
);

    localparam logic signed [31:0] POS_THR = $signed(THRESHOLD);
    localparam logic signed [31:0] NEG_THR = -$signed(THRESHOLD);

    logic hi_s;
    logic lo_s;
    logic level_d, level_q;
    logic known_d, known_q;

    assign hi_s = valid_i && ($signed(sample_i) > POS_THR);
    assign lo_s = valid_i && ($signed(sample_i) < NEG_THR);

    // Before any level is known a high sample is only an initial level, not an edge.
    assign rise_o        = hi_s && known_q && !level_q;
    assign level_o       = level_q;
    assign level_known_o = known_q;

    // Next held level: strict threshold crossings update it, the dead band holds it.
    always_comb begin
        level_d = level_q;
        known_d = known_q;
        if (hi_s) begin
            level_d = 1'b1;
            known_d = 1'b1;
        end else if (lo_s) begin
            level_d = 1'b0;
            known_d = 1'b1;
        end else begin
            level_d = level_q;
            known_d = known_q;
        end
    end

    // Held level registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= 1'b0;
            known_q <= 1'b0;
        end else begin
            level_q <= level_d;
            known_q <= known_d;
        end
    end

endmodule

// File: rtl/square_wave_detector.sv
// Tone receiver: measures the period between rising edges of the sliced
// input, strobes each period, and tracks frequency lock and signal loss.
module square_wave_detector
    import square_wave_detector_pkg::*;
#(
    parameter logic [31:0] THRESHOLD  = DEF_THRESHOLD,
    parameter int          COUNT_W    = DEF_COUNT_W,
    parameter logic [19:0] TOLERANCE  = DEF_TOLERANCE,
    parameter int          LOCK_COUNT = DEF_LOCK_COUNT
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic [31:0]        in,
    input  logic               in_valid,
    output logic               phase,
    output logic [COUNT_W-1:0] period,
    output logic               period_valid,
    output logic               locked,
    output logic               no_signal
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);
    localparam logic [3:0]         LOCK_N  = 4'(LOCK_COUNT);
    localparam logic [31:0]        TOL32   = {12'd0, TOLERANCE};

    state_e               state_d, state_q;
    logic [COUNT_W-1:0]   cnt_d, cnt_q;
    logic [COUNT_W-1:0]   period_d, period_q;
    logic                 pv_d, pv_q;
    logic                 locked_d, locked_q;
    logic                 nosig_d, nosig_q;
    logic [3:0]           match_d, match_q;
    logic                 first_d, first_q;
    logic                 level_s;
    logic                 level_known_s;
    logic                 rise_s;
    logic                 within_s;

    level_slicer #(
        .THRESHOLD (THRESHOLD)
    ) u_slicer (
        .clk_i         (CLOCK_50),
        .rst_ni        (reset_n),
        .sample_i      (in),
        .valid_i       (in_valid),
        .level_o       (level_s),
        .level_known_o (level_known_s),
        .rise_o        (rise_s)
    );

    assign within_s = abs_diff(32'(cnt_q), 32'(period_q)) <= TOL32;

    // FSM next state, period counter and lock tracking.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        pv_d     = 1'b0;
        locked_d = locked_q;
        nosig_d  = nosig_q;
        match_d  = match_q;
        first_d  = first_q;
        case (state_q)
            SEARCH, ARM: begin
                // A rise implies a known level, so SEARCH may jump straight to MEASURE.
                if (rise_s) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_ONE;
                    first_d = 1'b1;
                    nosig_d = 1'b0;
                end else if (level_known_s) begin
                    state_d = ARM;
                end else begin
                    state_d = state_q;
                end
            end
            MEASURE: begin
                if (rise_s) begin
                    period_d = cnt_q;
                    pv_d     = 1'b1;
                    cnt_d    = CNT_ONE;
                    nosig_d  = 1'b0;
                    first_d  = 1'b0;
                    if (first_q) begin
                        match_d = 4'd0;
                    end else if (within_s) begin
                        match_d = (match_q < LOCK_N) ? (match_q + 4'd1) : match_q;
                    end else begin
                        match_d = 4'd0;
                    end
                    locked_d = (match_d == LOCK_N);
                end else if (cnt_q == CNT_MAX) begin
                    nosig_d  = 1'b1;
                    locked_d = 1'b0;
                    match_d  = 4'd0;
                    state_d  = ARM;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= SEARCH;
            cnt_q    <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            nosig_q  <= 1'b1;
            match_q  <= 4'd0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            locked_q <= locked_d;
            nosig_q  <= nosig_d;
            match_q  <= match_d;
            first_q  <= first_d;
        end
    end

    assign phase        = level_s;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign no_signal    = nosig_q;

endmodule

// File: tb/tb_square_wave_detector.sv
// Directed bench for square_wave_detector with a shortened counter and
// scaled-down tone periods so every scenario runs in a few thousand cycles.
module tb_square_wave_detector;
    import square_wave_detector_pkg::*;

    localparam int          CW     = 10;
    localparam int          CMAX   = 1023;
    localparam logic [31:0] POS    = 32'd10_000_000;
    localparam logic [31:0] NEG    = -32'sd10_000_000;
    localparam logic [31:0] SUBPOS = 32'd4_000_000;
    localparam logic [31:0] SUBNEG = -32'sd4_000_000;

    logic          clk;
    logic          rst_n;
    logic [31:0]   smp_s;
    logic          vld_s;
    logic          phase_s;
    logic [CW-1:0] period_s;
    logic          pv_s;
    logic          locked_s;
    logic          nosig_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_pv_cyc = 0;
    int nos_cyc = -1;
    int per_q[$];
    int lock_q[$];

    square_wave_detector #(
        .THRESHOLD  (32'd5_000_000),
        .COUNT_W    (CW),
        .TOLERANCE  (20'd5),
        .LOCK_COUNT (4)
    ) dut (
        .CLOCK_50     (clk),
        .reset_n      (rst_n),
        .in           (smp_s),
        .in_valid     (vld_s),
        .phase        (phase_s),
        .period       (period_s),
        .period_valid (pv_s),
        .locked       (locked_s),
        .no_signal    (nosig_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] smp, input logic vld);
        smp_s = smp;
        vld_s = vld;
        @(posedge clk);
        #1;
        cyc++;
        if (pv_s) begin
            per_q.push_back(int'(period_s));
            lock_q.push_back(int'(locked_s));
            last_pv_cyc = cyc;
        end
    endtask

    // Alternating halves starting low: each low->high boundary is one rising edge.
    task automatic square(input int half, input int n_halves, input logic [31:0] hi, input logic [31:0] lo);
        for (int h = 0; h < n_halves; h++)
            for (int i = 0; i < half; i++)
                drive((h % 2 == 0) ? lo : hi, 1'b1);
    endtask

    task automatic clear_log();
        per_q.delete();
        lock_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        smp_s = 32'd0;
        vld_s = 1'b0;

        // Reset held with random traffic
        for (int i = 0; i < 6; i++) drive($urandom, 1'($urandom_range(0, 1)));
        check_eq("rst_phase",  32'(phase_s),  32'd0);
        check_eq("rst_period", 32'(period_s), 32'd0);
        check_eq("rst_pv",     32'(pv_s),     32'd0);
        check_eq("rst_locked", 32'(locked_s), 32'd0);
        check_eq("rst_nosig",  32'(nosig_s),  32'd1);
        rst_n = 1'b1;

        // Sub-threshold square wave never resolves a level
        clear_log();
        square(20, 8, SUBPOS, SUBNEG);
        check_eq("sub_phase", 32'(phase_s), 32'd0);
        check_eq("sub_pv",    32'(per_q.size()), 32'd0);
        check_eq("sub_nosig", 32'(nosig_s), 32'd1);
        check_eq("sub_state", 32'(dut.state_q), 32'(SEARCH));

        // Tone at period 200: five periods reported, lock with the fifth
        clear_log();
        square(100, 12, POS, NEG);
        check_eq("tone_npv",   32'(per_q.size()), 32'd5);
        for (int k = 0; k < per_q.size(); k++)
            check_eq("tone_period", 32'(per_q[k]), 32'd200);
        check_eq("tone_lock4", 32'(lock_q[3]), 32'd0);
        check_eq("tone_lock5", 32'(lock_q[4]), 32'd1);
        check_eq("tone_nosig", 32'(nosig_s), 32'd0);
        check_eq("tone_phase", 32'(phase_s), 32'd1);

        // Glitches inside the low half stay in the dead band or below the level
        clear_log();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 100; i++)
                drive((i == 30) ? 32'd0 : (i == 60) ? 32'd3_000_000 : NEG, 1'b1);
            for (int i = 0; i < 100; i++) drive(POS, 1'b1);
        end
        check_eq("glitch_npv", 32'(per_q.size()), 32'd2);
        check_eq("glitch_p0",  32'(per_q[0]), 32'd200);
        check_eq("glitch_p1",  32'(per_q[1]), 32'd200);
        check_eq("glitch_lk",  32'(locked_s), 32'd1);

        // Frequency step to period 120: first mixed period 160, relock after 4 matches
        clear_log();
        square(60, 12, POS, NEG);
        check_eq("step_npv", 32'(per_q.size()), 32'd6);
        check_eq("step_p0",  32'(per_q[0]),  32'd160);
        check_eq("step_l0",  32'(lock_q[0]), 32'd0);
        check_eq("step_p1",  32'(per_q[1]),  32'd120);
        check_eq("step_l4",  32'(lock_q[4]), 32'd0);
        check_eq("step_p5",  32'(per_q[5]),  32'd120);
        check_eq("step_l5",  32'(lock_q[5]), 32'd1);

        // Signal loss: input stuck high until the counter saturates
        clear_log();
        for (int i = 0; i < 2000 && nos_cyc < 0; i++) begin
            drive(POS, 1'b1);
            if (nosig_s) nos_cyc = cyc;
        end
        check_eq("loss_delay",  32'(nos_cyc - last_pv_cyc), 32'(CMAX));
        check_eq("loss_locked", 32'(locked_s), 32'd0);
        check_eq("loss_npv",    32'(per_q.size()), 32'd0);
        check_eq("loss_period", 32'(period_s), 32'd120);
        check_eq("loss_state",  32'(dut.state_q), 32'(ARM));
        square(100, 4, POS, NEG);
        check_eq("rearm_npv",   32'(per_q.size()), 32'd1);
        check_eq("rearm_per",   32'(per_q.size() > 0 ? per_q[0] : -1), 32'd200);
        check_eq("rearm_lock",  32'(locked_s), 32'd0);
        check_eq("rearm_nosig", 32'(nosig_s), 32'd0);

        // Asynchronous reset between clock edges
        square(100, 10, POS, NEG);
        check_eq("pre_rst_lock", 32'(locked_s), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_phase",  32'(phase_s),  32'd0);
        check_eq("arst_period", 32'(period_s), 32'd0);
        check_eq("arst_locked", 32'(locked_s), 32'd0);
        check_eq("arst_nosig",  32'(nosig_s),  32'd1);
        check_eq("arst_state",  32'(dut.state_q), 32'(SEARCH));
        #3;
        rst_n = 1'b1;
        clear_log();
        square(100, 6, POS, NEG);
        check_eq("post_npv", 32'(per_q.size()), 32'd2);
        check_eq("post_per", 32'(period_s), 32'd200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
